// File: rtl/mem_arbiter_pkg.sv
// Shared cache/memory bus structs plus the arbiter's state and owner types.
// Used by mem_arbiter and rr_arbiter2.
package mem_arbiter_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;
    localparam int MASK_W = DATA_W / 8;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
    } mem_r_req_bus_t;

    typedef struct packed {
        logic [DATA_W-1:0] rdata;
    } mem_r_resp_bus_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
        logic [MASK_W-1:0] wmask;
    } mem_w_req_bus_t;

    typedef struct packed {
        logic [1:0] resp;
    } mem_w_resp_bus_t;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        R_ISSUE = 3'd1,
        R_WAIT  = 3'd2,
        W_ISSUE = 3'd3,
        W_WAIT  = 3'd4
    } arb_state_t;

    typedef enum logic {
        OWNER_M0 = 1'b0,
        OWNER_M1 = 1'b1
    } arb_owner_t;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-requester round-robin pick. last_grant starts at M1 so M0 wins the
// first contended round; it only moves when grant_en accepts a pick.
module rr_arbiter2
    import mem_arbiter_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] req,
    input  logic       grant_en,
    output logic       grant_valid,
    output arb_owner_t grant
);

    arb_owner_t last_grant;

    always_comb begin
        grant_valid = |req;
        grant       = OWNER_M0;
        if (req == 2'b11) begin
            grant = (last_grant == OWNER_M0) ? OWNER_M1 : OWNER_M0;
        end else if (req[1]) begin
            grant = OWNER_M1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            last_grant <= OWNER_M1;
        end else if (grant_en && grant_valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/mem_arbiter.sv
// Shares one memory port between the I-cache (M0, read) and D-cache (M1, read +
// write-back). Optional grant counters are built when MEM_ARB_PERF_CNT_EN is defined.
module mem_arbiter
    import mem_arbiter_pkg::*;
#(
    parameter int CNT_WIDTH = 32
) (
    input  logic                 clk,
    input  logic                 rst,

    input  mem_r_req_bus_t       m0_r_req,
    input  logic                 m0_r_req_valid,
    output logic                 m0_r_req_ready,
    output mem_r_resp_bus_t      m0_r_resp,
    output logic                 m0_r_resp_valid,

    input  mem_r_req_bus_t       m1_r_req,
    input  logic                 m1_r_req_valid,
    output logic                 m1_r_req_ready,
    output mem_r_resp_bus_t      m1_r_resp,
    output logic                 m1_r_resp_valid,

    input  mem_w_req_bus_t       m1_w_req,
    input  logic                 m1_w_req_valid,
    output logic                 m1_w_req_ready,
    output mem_w_resp_bus_t      m1_w_resp,
    output logic                 m1_w_resp_valid,

    output mem_r_req_bus_t       mem_r_req,
    output logic                 mem_r_req_valid,
    input  logic                 mem_r_req_ready,
    input  mem_r_resp_bus_t      mem_r_resp,
    input  logic                 mem_r_resp_valid,

    output mem_w_req_bus_t       mem_w_req,
    output logic                 mem_w_req_valid,
    input  logic                 mem_w_req_ready,
    input  mem_w_resp_bus_t      mem_w_resp,
    input  logic                 mem_w_resp_valid,

    output logic [CNT_WIDTH-1:0] perf_grant_cnt0,
    output logic [CNT_WIDTH-1:0] perf_grant_cnt1,

    output arb_state_t           dbg_state
);

    // Handshake: a request transfers on the edge where valid && ready are both
    // high; the master holds its bus stable until then. Response valids are
    // single-cycle strobes with no back-pressure.

    arb_state_t state;
    arb_state_t state_nxt;
    arb_owner_t owner;

    logic       grant_en;
    logic       grant_valid;
    arb_owner_t grant;
    logic       m1_any;

    assign m1_any    = m1_r_req_valid | m1_w_req_valid;
    assign grant_en  = (state == IDLE);
    assign dbg_state = state;

    rr_arbiter2 u_rr (
        .clk         (clk),
        .rst         (rst),
        .req         ({m1_any, m0_r_req_valid}),
        .grant_en    (grant_en),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            owner <= OWNER_M0;
        end else begin
            state <= state_nxt;
            if (grant_en && grant_valid) begin
                owner <= grant;
            end
        end
    end

    // Request and response paths are purely combinational from the owner; the
    // transaction type is carried by the state itself.
    always_comb begin
        state_nxt       = state;
        m0_r_req_ready  = 1'b0;
        m1_r_req_ready  = 1'b0;
        m1_w_req_ready  = 1'b0;
        m0_r_resp       = '0;
        m0_r_resp_valid = 1'b0;
        m1_r_resp       = '0;
        m1_r_resp_valid = 1'b0;
        m1_w_resp       = '0;
        m1_w_resp_valid = 1'b0;
        mem_r_req       = '0;
        mem_r_req_valid = 1'b0;
        mem_w_req       = '0;
        mem_w_req_valid = 1'b0;

        case (state)
            IDLE: begin
                if (grant_valid) begin
                    // Within M1 the write-back goes first so the dirty line
                    // leaves before the refill read that may replace it.
                    if (grant == OWNER_M1 && m1_w_req_valid) begin
                        state_nxt = W_ISSUE;
                    end else begin
                        state_nxt = R_ISSUE;
                    end
                end
            end

            R_ISSUE: begin
                mem_r_req_valid = 1'b1;
                if (owner == OWNER_M1) begin
                    mem_r_req      = m1_r_req;
                    m1_r_req_ready = mem_r_req_ready;
                end else begin
                    mem_r_req      = m0_r_req;
                    m0_r_req_ready = mem_r_req_ready;
                end
                if (mem_r_req_ready) begin
                    state_nxt = R_WAIT;
                end
            end

            R_WAIT: begin
                if (mem_r_resp_valid) begin
                    if (owner == OWNER_M1) begin
                        m1_r_resp       = mem_r_resp;
                        m1_r_resp_valid = 1'b1;
                    end else begin
                        m0_r_resp       = mem_r_resp;
                        m0_r_resp_valid = 1'b1;
                    end
                    state_nxt = IDLE;
                end
            end

            W_ISSUE: begin
                mem_w_req_valid = 1'b1;
                mem_w_req       = m1_w_req;
                m1_w_req_ready  = mem_w_req_ready;
                if (mem_w_req_ready) begin
                    state_nxt = W_WAIT;
                end
            end

            W_WAIT: begin
                if (mem_w_resp_valid) begin
                    m1_w_resp       = mem_w_resp;
                    m1_w_resp_valid = 1'b1;
                    state_nxt       = IDLE;
                end
            end

            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

`ifdef MEM_ARB_PERF_CNT_EN
    logic [CNT_WIDTH-1:0] cnt0;
    logic [CNT_WIDTH-1:0] cnt1;

    // Saturating so long runs never wrap back to a misleadingly small count.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt0 <= '0;
            cnt1 <= '0;
        end else if (grant_en && grant_valid) begin
            if (grant == OWNER_M0 && cnt0 != '1) begin
                cnt0 <= cnt0 + 1'b1;
            end
            if (grant == OWNER_M1 && cnt1 != '1) begin
                cnt1 <= cnt1 + 1'b1;
            end
        end
    end

    assign perf_grant_cnt0 = cnt0;
    assign perf_grant_cnt1 = cnt1;
`else
    assign perf_grant_cnt0 = '0;
    assign perf_grant_cnt1 = '0;
`endif

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: grant table from reset, directed corner sequences,
// then randomized traffic against a transaction-level reference model.
module tb_mem_arbiter;
    import mem_arbiter_pkg::*;

    localparam int CW = 32;

    logic clk = 1'b0;
    logic rst;

    mem_r_req_bus_t  m0_r_req, m1_r_req, mem_r_req;
    mem_r_resp_bus_t m0_r_resp, m1_r_resp, mem_r_resp;
    mem_w_req_bus_t  m1_w_req, mem_w_req;
    mem_w_resp_bus_t m1_w_resp, mem_w_resp;
    logic m0_r_req_valid, m0_r_req_ready, m0_r_resp_valid;
    logic m1_r_req_valid, m1_r_req_ready, m1_r_resp_valid;
    logic m1_w_req_valid, m1_w_req_ready, m1_w_resp_valid;
    logic mem_r_req_valid, mem_r_req_ready, mem_r_resp_valid;
    logic mem_w_req_valid, mem_w_req_ready, mem_w_resp_valid;
    logic [CW-1:0] perf_grant_cnt0, perf_grant_cnt1;
    arb_state_t dbg_state;

    always #5 clk = ~clk;

    mem_arbiter #(.CNT_WIDTH(CW)) dut (
        .clk(clk), .rst(rst),
        .m0_r_req(m0_r_req), .m0_r_req_valid(m0_r_req_valid), .m0_r_req_ready(m0_r_req_ready),
        .m0_r_resp(m0_r_resp), .m0_r_resp_valid(m0_r_resp_valid),
        .m1_r_req(m1_r_req), .m1_r_req_valid(m1_r_req_valid), .m1_r_req_ready(m1_r_req_ready),
        .m1_r_resp(m1_r_resp), .m1_r_resp_valid(m1_r_resp_valid),
        .m1_w_req(m1_w_req), .m1_w_req_valid(m1_w_req_valid), .m1_w_req_ready(m1_w_req_ready),
        .m1_w_resp(m1_w_resp), .m1_w_resp_valid(m1_w_resp_valid),
        .mem_r_req(mem_r_req), .mem_r_req_valid(mem_r_req_valid), .mem_r_req_ready(mem_r_req_ready),
        .mem_r_resp(mem_r_resp), .mem_r_resp_valid(mem_r_resp_valid),
        .mem_w_req(mem_w_req), .mem_w_req_valid(mem_w_req_valid), .mem_w_req_ready(mem_w_req_ready),
        .mem_w_resp(mem_w_resp), .mem_w_resp_valid(mem_w_resp_valid),
        .perf_grant_cnt0(perf_grant_cnt0), .perf_grant_cnt1(perf_grant_cnt1),
        .dbg_state(dbg_state)
    );

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- clock/reset and driver tasks ----------------
    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        m0_r_req = '0; m0_r_req_valid = 1'b0;
        m1_r_req = '0; m1_r_req_valid = 1'b0;
        m1_w_req = '0; m1_w_req_valid = 1'b0;
        mem_r_req_ready = 1'b0; mem_r_resp = '0; mem_r_resp_valid = 1'b0;
        mem_w_req_ready = 1'b0; mem_w_resp = '0; mem_w_resp_valid = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
    endtask

    function automatic logic [31:0] rdata_of(input logic [31:0] a);
        return a * 32'd3 + 32'd1;
    endfunction

    // ---------------- table of first grants out of reset ----------------
    typedef struct {
        logic        m0v;
        logic        m1rv;
        logic        m1wv;
        arb_state_t  st;
        logic [31:0] addr;
    } vec_t;

    vec_t vecs[8];

    // ---------------- random-phase reference model state ----------------
    logic [31:0]    q0[$];
    logic [31:0]    q1r[$];
    mem_w_req_bus_t q1w[$];
    logic [31:0]    exp_q[$];   // expected read data for the transaction in flight
    int         ph;             // 0: arbitration slot, 1: request on the bus, 2: awaiting response
    arb_owner_t m_owner, m_last;
    logic       m_write;
    logic       hs_m0, hs_m1r, hs_m1w;
    logic       mr_busy, mw_busy;
    int         mr_wait, mw_wait;
    logic [31:0] mr_addr, exp_addr;
    logic [1:0]  mw_code;
    int          n_tx;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        bad++;
        $display("test done: total=%0d bad=%0d", total, bad);
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] act_addr;
        int          grants;
        logic        resp_due;
        logic [CW-1:0] exp_c;

        vecs[0] = '{1'b1, 1'b0, 1'b0, R_ISSUE, 32'h100};
        vecs[1] = '{1'b0, 1'b1, 1'b0, R_ISSUE, 32'h200};
        vecs[2] = '{1'b0, 1'b0, 1'b1, W_ISSUE, 32'h300};
        vecs[3] = '{1'b0, 1'b1, 1'b1, W_ISSUE, 32'h300};
        vecs[4] = '{1'b1, 1'b1, 1'b0, R_ISSUE, 32'h100};
        vecs[5] = '{1'b1, 1'b0, 1'b1, R_ISSUE, 32'h100};
        vecs[6] = '{1'b1, 1'b1, 1'b1, R_ISSUE, 32'h100};
        vecs[7] = '{1'b0, 1'b0, 1'b0, IDLE,    32'h0};

        // Reset state
        do_reset();
        sample();
        check("rst_state", dbg_state, IDLE);
        check("rst_valids", {mem_r_req_valid, mem_w_req_valid, m0_r_req_ready, m1_r_req_ready,
                             m1_w_req_ready, m0_r_resp_valid, m1_r_resp_valid, m1_w_resp_valid}, 8'h0);
        check("rst_buses", {mem_r_req, m0_r_resp, m1_r_resp, m1_w_resp}, 64'h0);
        check("rst_cnt", {perf_grant_cnt0, perf_grant_cnt1}, 64'h0);

        // Table: first grant after reset for every request combination
        for (int i = 0; i < 8; i++) begin
            do_reset();
            m0_r_req.addr = 32'h100; m0_r_req_valid = vecs[i].m0v;
            m1_r_req.addr = 32'h200; m1_r_req_valid = vecs[i].m1rv;
            m1_w_req.addr = 32'h300; m1_w_req.data = 32'hA5A5_0300; m1_w_req.wmask = 4'hC;
            m1_w_req_valid = vecs[i].m1wv;
            sample();
            check("tbl_idle_no_valid", {mem_r_req_valid, mem_w_req_valid}, 2'b00);
            next_cycle();
            sample();
            act_addr = (vecs[i].st == W_ISSUE) ? mem_w_req.addr : mem_r_req.addr;
            check("tbl_state", dbg_state, vecs[i].st);
            check("tbl_valids", {mem_r_req_valid, mem_w_req_valid},
                  {vecs[i].st == R_ISSUE, vecs[i].st == W_ISSUE});
            check("tbl_addr", act_addr, vecs[i].addr);
            check("tbl_readies", {m0_r_req_ready, m1_r_req_ready, m1_w_req_ready}, 3'b000);
            if (vecs[i].st == W_ISSUE) begin
                check("tbl_wdata", mem_w_req.data, 32'hA5A5_0300);
                check("tbl_wmask", mem_w_req.wmask, 4'hC);
            end
        end

        // H1: single M0 read, memory ready at once, data three cycles later
        do_reset();
        m0_r_req.addr = 32'h40; m0_r_req_valid = 1'b1; mem_r_req_ready = 1'b1;
        sample();
        check("h1_cycle1_idle", {mem_r_req_valid, m0_r_req_ready}, 2'b00);
        next_cycle();
        sample();
        check("h1_issue_valid", mem_r_req_valid, 1'b1);
        check("h1_issue_addr", mem_r_req.addr, 32'h40);
        check("h1_issue_ready", {m0_r_req_ready, m1_r_req_ready}, 2'b10);
        next_cycle();
        m0_r_req_valid = 1'b0; m0_r_req = '0; mem_r_req_ready = 1'b0;
        sample();
        check("h1_wait_state", dbg_state, R_WAIT);
        next_cycle();
        next_cycle();
        mem_r_resp_valid = 1'b1; mem_r_resp.rdata = 32'hCAFE_0040;
        sample();
        check("h1_resp_valid", {m0_r_resp_valid, m1_r_resp_valid}, 2'b10);
        check("h1_resp_data", m0_r_resp.rdata, 32'hCAFE_0040);
        check("h1_m1_data_zero", m1_r_resp.rdata, 32'h0);
        next_cycle();
        mem_r_resp_valid = 1'b0; mem_r_resp = '0;
        sample();
        check("h1_pulse_once", m0_r_resp_valid, 1'b0);
        check("h1_back_idle", dbg_state, IDLE);

        // H2: memory stalls the read for five cycles
        next_cycle();
        m0_r_req.addr = 32'h80; m0_r_req_valid = 1'b1;
        next_cycle();
        for (int i = 0; i < 5; i++) begin
            sample();
            check("h2_stall_state", dbg_state, R_ISSUE);
            check("h2_stall_ready", m0_r_req_ready, 1'b0);
            check("h2_stall_addr", mem_r_req.addr, 32'h80);
            next_cycle();
        end
        mem_r_req_ready = 1'b1;
        sample();
        check("h2_accept_ready", m0_r_req_ready, 1'b1);
        next_cycle();
        m0_r_req_valid = 1'b0; m0_r_req = '0; mem_r_req_ready = 1'b0;
        sample();
        check("h2_wait_state", dbg_state, R_WAIT);

        // H3: reset lands while the read waits; the arriving response is dropped
        next_cycle();
        mem_r_resp_valid = 1'b1; mem_r_resp.rdata = 32'hDEAD_BEEF;
        #1;
        check("h3_pre_rst_resp", m0_r_resp_valid, 1'b1);
        rst = 1'b1;
        #1;
        check("h3_async_state", dbg_state, IDLE);
        check("h3_async_resp", {m0_r_resp_valid, m1_r_resp_valid, mem_r_req_valid}, 3'b000);
        check("h3_async_data", m0_r_resp.rdata, 32'h0);
        clear_inputs();
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        m0_r_req.addr = 32'h100; m0_r_req_valid = 1'b1;
        m1_r_req.addr = 32'h200; m1_r_req_valid = 1'b1;
        next_cycle();
        sample();
        check("h3_first_grant_m0", mem_r_req.addr, 32'h100);

        // H4: both masters read continuously; grants alternate, counters track
        do_reset();
        m0_r_req.addr = 32'h100; m0_r_req_valid = 1'b1;
        m1_r_req.addr = 32'h200; m1_r_req_valid = 1'b1;
        mem_r_req_ready = 1'b1;
        grants = 0;
        resp_due = 1'b0;
        for (int cyc = 0; cyc < 200 && grants < 10; cyc++) begin
            next_cycle();
            mem_r_resp_valid = resp_due;
            mem_r_resp.rdata = 32'h5000 + cyc;
            resp_due = 1'b0;
            sample();
            if (mem_r_req_valid && mem_r_req_ready) begin
                check("h4_alt_owner", mem_r_req.addr, (grants % 2 == 0) ? 32'h100 : 32'h200);
                grants++;
                resp_due = 1'b1;
            end
        end
        check("h4_grant_count", grants, 10);
`ifdef MEM_ARB_PERF_CNT_EN
        exp_c = 5;
`else
        exp_c = 0;
`endif
        check("h4_cnt0", perf_grant_cnt0, exp_c);
        check("h4_cnt1", perf_grant_cnt1, exp_c);

        // Randomized traffic against the reference model
        do_reset();
        ph = 0; m_last = OWNER_M1; m_owner = OWNER_M0; m_write = 1'b0;
        hs_m0 = 0; hs_m1r = 0; hs_m1w = 0;
        mr_busy = 0; mw_busy = 0; mr_wait = 0; mw_wait = 0; mr_addr = '0; mw_code = '0;
        exp_addr = '0; n_tx = 0;
        for (int cyc = 0; cyc < 3000; cyc++) begin
            next_cycle();
            // Consequences of the handshakes seen at the previous sample
            if (hs_m0) begin mr_addr = q0[0]; void'(q0.pop_front()); end
            if (hs_m1r) begin mr_addr = q1r[0]; void'(q1r.pop_front()); end
            if (hs_m0 || hs_m1r) begin mr_busy = 1; mr_wait = $urandom_range(0, 3); end
            if (hs_m1w) begin
                void'(q1w.pop_front());
                mw_busy = 1; mw_wait = $urandom_range(0, 3); mw_code = 2'($urandom_range(0, 3));
            end
            // Masters generate new work
            if (q0.size() < 2 && $urandom_range(0, 3) == 0) q0.push_back($urandom & 32'hFFFF_FFFC);
            if (q1r.size() < 2 && $urandom_range(0, 4) == 0) q1r.push_back($urandom & 32'hFFFF_FFFC);
            if (q1w.size() < 2 && $urandom_range(0, 5) == 0)
                q1w.push_back('{addr: $urandom & 32'hFFFF_FFFC, data: $urandom, wmask: 4'($urandom_range(1, 15))});
            m0_r_req_valid = (q0.size() > 0);  m0_r_req.addr = m0_r_req_valid ? q0[0] : 32'h0;
            m1_r_req_valid = (q1r.size() > 0); m1_r_req.addr = m1_r_req_valid ? q1r[0] : 32'h0;
            m1_w_req_valid = (q1w.size() > 0); m1_w_req = m1_w_req_valid ? q1w[0] : '0;
            // Memory: random back-pressure, variable latency, occasional stray responses
            mem_r_req_ready = ($urandom_range(0, 2) != 0);
            mem_w_req_ready = ($urandom_range(0, 2) != 0);
            mem_r_resp_valid = 1'b0; mem_r_resp = '0;
            mem_w_resp_valid = 1'b0; mem_w_resp = '0;
            if (mr_busy) begin
                if (mr_wait == 0) begin
                    mem_r_resp_valid = 1'b1; mem_r_resp.rdata = rdata_of(mr_addr); mr_busy = 0;
                end else mr_wait--;
            end else if ($urandom_range(0, 15) == 0) begin
                mem_r_resp_valid = 1'b1; mem_r_resp.rdata = $urandom;
            end
            if (mw_busy) begin
                if (mw_wait == 0) begin
                    mem_w_resp_valid = 1'b1; mem_w_resp.resp = mw_code; mw_busy = 0;
                end else mw_wait--;
            end else if ($urandom_range(0, 15) == 0) begin
                mem_w_resp_valid = 1'b1; mem_w_resp.resp = 2'($urandom_range(0, 3));
            end

            sample();
            hs_m0 = 0; hs_m1r = 0; hs_m1w = 0;
            case (ph)
                0: begin
                    check("rnd_idle_bus", {mem_r_req_valid, mem_w_req_valid, m0_r_req_ready,
                                           m1_r_req_ready, m1_w_req_ready}, 5'b0);
                    check("rnd_idle_resp", {m0_r_resp_valid, m1_r_resp_valid, m1_w_resp_valid}, 3'b0);
                    if (m0_r_req_valid || m1_r_req_valid || m1_w_req_valid) begin
                        if (m0_r_req_valid && (m1_r_req_valid || m1_w_req_valid))
                            m_owner = (m_last == OWNER_M0) ? OWNER_M1 : OWNER_M0;
                        else
                            m_owner = m0_r_req_valid ? OWNER_M0 : OWNER_M1;
                        m_write = (m_owner == OWNER_M1) && m1_w_req_valid;
                        m_last = m_owner;
                        ph = 1;
                    end
                end
                1: begin
                    check("rnd_issue_resp", {m0_r_resp_valid, m1_r_resp_valid, m1_w_resp_valid}, 3'b0);
                    if (m_write) begin
                        check("rnd_w_valids", {mem_r_req_valid, mem_w_req_valid}, 2'b01);
                        check("rnd_w_addr", mem_w_req.addr, q1w[0].addr);
                        check("rnd_w_data", mem_w_req.data, q1w[0].data);
                        check("rnd_w_mask", mem_w_req.wmask, q1w[0].wmask);
                        check("rnd_w_ready", {m0_r_req_ready, m1_r_req_ready, m1_w_req_ready},
                              {2'b00, mem_w_req_ready});
                        if (mem_w_req_ready) begin hs_m1w = 1; ph = 2; end
                    end else begin
                        exp_addr = (m_owner == OWNER_M0) ? q0[0] : q1r[0];
                        check("rnd_r_valids", {mem_r_req_valid, mem_w_req_valid}, 2'b10);
                        check("rnd_r_addr", mem_r_req.addr, exp_addr);
                        check("rnd_r_ready", {m0_r_req_ready, m1_r_req_ready, m1_w_req_ready},
                              {m_owner == OWNER_M0 && mem_r_req_ready,
                               m_owner == OWNER_M1 && mem_r_req_ready, 1'b0});
                        if (mem_r_req_ready) begin
                            if (m_owner == OWNER_M0) hs_m0 = 1; else hs_m1r = 1;
                            exp_q.push_back(rdata_of(exp_addr));
                            ph = 2;
                        end
                    end
                end
                default: begin
                    check("rnd_wait_bus", {mem_r_req_valid, mem_w_req_valid, m0_r_req_ready,
                                           m1_r_req_ready, m1_w_req_ready}, 5'b0);
                    if (m_write && mem_w_resp_valid) begin
                        check("rnd_w_resp_route", {m0_r_resp_valid, m1_r_resp_valid, m1_w_resp_valid}, 3'b001);
                        check("rnd_w_resp_code", m1_w_resp.resp, mw_code);
                        ph = 0; n_tx++;
                    end else if (!m_write && mem_r_resp_valid && exp_q.size() > 0) begin
                        check("rnd_r_resp_route", {m0_r_resp_valid, m1_r_resp_valid, m1_w_resp_valid},
                              {m_owner == OWNER_M0, m_owner == OWNER_M1, 1'b0});
                        check("rnd_r_resp_data", (m_owner == OWNER_M0) ? m0_r_resp.rdata : m1_r_resp.rdata,
                              exp_q[0]);
                        check("rnd_r_other_zero", (m_owner == OWNER_M0) ? m1_r_resp.rdata : m0_r_resp.rdata,
                              32'h0);
                        void'(exp_q.pop_front());
                        ph = 0; n_tx++;
                    end else begin
                        check("rnd_wait_quiet", {m0_r_resp_valid, m1_r_resp_valid, m1_w_resp_valid}, 3'b0);
                    end
                end
            endcase
        end
        check("rnd_progress", n_tx >= 100, 1'b1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Shares the single backing-memory port between the instruction cache (master 0, read-only) and the data cache (master 1, read and write-back).
- Grants one transaction at a time and forwards its request to memory. Routes the memory response back to the owning master.
- Sits between both L1 caches and the memory model/bus adapter. Uses the same mem_r/mem_w request/response bus structs as the caches.

Parameters:
- CNT_WIDTH, 32, width of the optional per-master grant counters (saturating).

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- m0_r_req  in  mem_r_req_bus_t  master 0 read request (addr)
- m0_r_req_valid  in  1  master 0 read request valid
- m0_r_req_ready  out  1  master 0 read request accepted
- m0_r_resp  out  mem_r_resp_bus_t  read data to master 0
- m0_r_resp_valid  out  1  master 0 response strobe
- m1_r_req / m1_r_req_valid / m1_r_req_ready / m1_r_resp / m1_r_resp_valid  same as master 0, for master 1
- m1_w_req  in  mem_w_req_bus_t  master 1 write-back (addr, data, wmask)
- m1_w_req_valid  in  1  master 1 write request valid
- m1_w_req_ready  out  1  master 1 write request accepted
- m1_w_resp  out  mem_w_resp_bus_t  write ack to master 1
- m1_w_resp_valid  out  1  master 1 write response strobe
- mem_r_req  out  mem_r_req_bus_t; mem_r_req_valid out 1; mem_r_req_ready in 1; mem_r_resp in mem_r_resp_bus_t; mem_r_resp_valid in 1  memory read channel
- mem_w_req  out  mem_w_req_bus_t; mem_w_req_valid out 1; mem_w_req_ready in 1; mem_w_resp in mem_w_resp_bus_t; mem_w_resp_valid in 1  memory write channel
- perf_grant_cnt0, perf_grant_cnt1  out  CNT_WIDTH  grant counts (optional feature)

Behaviour:
- Reset state and outputs:
  - Reset is asynchronous and active-high on rst; clock is clk.
  - During reset: state=IDLE, last_grant=1 (so master 0 wins the first tie).
  - All valid/ready outputs 0; all bus outputs '0.
- States: IDLE, R_ISSUE, R_WAIT, W_ISSUE, W_WAIT.
- Owner register: owner (0/1) latched in IDLE.
- IDLE, request selection:
  - Candidates are m0_r (M0), m1_w (M1), m1_r (M1). Within M1, write has priority over read.
  - If only one master requests, it is granted.
  - If both request, round-robin: grant the master != last_grant.
- IDLE, grant action:
  - Latch owner and type; update last_grant.
  - Go to R_ISSUE or W_ISSUE. Arbitration adds exactly 1 cycle of latency.
  - No ready is asserted in IDLE.
- R_ISSUE / W_ISSUE:
  - Drive mem_*_req combinationally from the owner's request bus; mem_*_req_valid=1.
  - Owner's *_req_ready = mem_*_req_ready (same cycle); all other readies 0.
  - On mem ready go to *_WAIT, else hold.
  - Masters hold their request stable until ready. The request is not re-latched.
- R_WAIT / W_WAIT:
  - On mem_*_resp_valid, forward the resp bus and a 1-cycle valid pulse to the owner only, then go to IDLE.
  - Non-owner resp outputs stay 0. Responses arriving in any other state are dropped.
- Fairness/back-to-back:
  - A master re-requesting in the cycle after its response competes normally. With both masters busy, grants alternate.
  - Minimum per-transaction overhead is 1 IDLE cycle.
- Outstanding limit:
  - Exactly one transaction outstanding. Read and write channels are never active simultaneously.
- Simultaneous M1 read+write valid: write served first; the read waits for the next round.
- Mid-operation reset: abort to IDLE; the in-flight transaction is dropped with no response delivered. Memory is reset on the same rst.
- Request valid deasserted while in ISSUE is a protocol violation. The arbiter keeps driving the latched owner's current bus; behaviour is otherwise undefined.

Optional Feature:
- MEM_ARB_PERF_CNT_EN defined:
  - perf_grant_cnt0/1 increment by 1 on each IDLE grant to the respective master.
  - They saturate at all-ones and are reset to 0.
- Undefined: counters are not instantiated; ports are present and tied to 0.

Decomposition:
- cache_pkg gains arb_state_t (the five-state enum) and arb_owner_t (1-bit master id).
- The existing mem_*_bus_t structs are reused unchanged.
- One sub-module: rr_arbiter2 (2-requester round-robin pick with last_grant register and grant-enable input). The rest stays flat.

Test Plan:
- Reset release, M0 read addr 0x40, memory ready at once, rdata after 3 cycles -> mem_r_req_valid from cycle 2; m0_r_resp_valid pulses with the memory data; m1 resp stays 0.
- M0 read and M1 read valid together, both re-request forever -> grants strictly alternate M0, M1, M0, M1; first grant is M0.
- M1 write and read valid together -> W_ISSUE first (wmask/data passed through), m1_w_resp_valid, then the M1 read is issued.
- mem_r_req_ready held low 5 cycles -> arbiter stays in R_ISSUE, the owner's ready stays 0, mem_r_req stable; proceeds once ready rises.
- rst asserted in R_WAIT -> all outputs 0 asynchronously; no response pulse delivered; a fresh grant after release goes to M0.
- With MEM_ARB_PERF_CNT_EN and 10 alternating grants -> cnt0=5, cnt1=5. Without the macro -> both read 0.
